// File: rtl/dac_tx_pkg.sv
// Shared types and frame formatting for the DAC SPI transmitter.
// Frames are built MSB-aligned in a wide word so any legal width can slice from the top.
package dac_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic [3:0]  CMD        = 4'b0011;
   localparam int unsigned FRAME_MAX  = 64;
   localparam int unsigned SAMPLE_MAX = FRAME_MAX - 4;

   // Sample arrives right-justified; it is moved up to sit directly below CMD.
   function automatic logic [FRAME_MAX-1:0] build_frame(input logic [SAMPLE_MAX-1:0] sample,
                                                        input int unsigned data_w);
      logic [SAMPLE_MAX-1:0] body;
      body = sample << (SAMPLE_MAX - data_w);
      return {CMD, body};
   endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV enabled cycles, starting low.
// rise_o/fall_o flag the cycle whose closing edge makes sclk rise/fall.
module dac_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             wrap;

   always_comb begin
      wrap   = en_i && (div_q == DIV_LAST);
      div_d  = div_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         div_d  = '0;
         sclk_d = 1'b0;
      end else if (wrap) begin
         div_d  = '0;
         sclk_d = !sclk_q;
      end else begin
         div_d  = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = wrap && !sclk_q;
   assign fall_o = wrap && sclk_q;

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter: one sample per frame {CMD, sample, zero pad}, MSB first.
// Define DAC_TX_LDAC_EN to add dac_ldac_n, pulsed low after cs_n rises.
module dac_spi_tx
   import dac_tx_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int FRAME_WIDTH = 16,
   parameter int CLK_DIV     = 2,
   parameter int CS_GAP      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_ready,
   output logic                  dac_cs_n,
   output logic                  dac_sclk,
   output logic                  dac_mosi,
   output logic                  busy,
   output logic                  frame_done
`ifdef DAC_TX_LDAC_EN
   ,output logic                 dac_ldac_n
`endif
);

`ifdef DAC_TX_LDAC_EN
   localparam int HOLD_LEN = CS_GAP + CLK_DIV;
`else
   localparam int HOLD_LEN = CS_GAP;
`endif
   localparam int BIT_W  = $clog2(FRAME_WIDTH + 1);
   localparam int HOLD_W = $clog2(HOLD_LEN + 1);
   localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(FRAME_WIDTH);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN - 1);

   state_e                 state_q, state_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [FRAME_WIDTH-1:0] sh_q, sh_d;
   logic                   done_q, done_d;
   logic [FRAME_WIDTH-1:0] frame_w;
   logic                   accept;
   logic                   sclk_w, rise_w, fall_w;

   assign frame_w = FRAME_WIDTH'(build_frame(SAMPLE_MAX'(sample), DATA_WIDTH)
                                 >> (FRAME_MAX - FRAME_WIDTH));

   assign sample_ready = (state_q == IDLE) && en && !rst;
   assign accept       = sample_valid && sample_ready;

   dac_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q == SHIFT),
      .sclk_o (sclk_w),
      .rise_o (rise_w),
      .fall_o (fall_w)
   );

   // Bits are counted on sclk rises; the fall after the last counted rise ends the frame.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      hold_d  = hold_q;
      sh_d    = sh_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               bit_d   = BIT_LOAD;
               sh_d    = frame_w;
            end
         end
         SHIFT: begin
            if (rise_w) begin
               bit_d = bit_q - 1'b1;
            end
            if (fall_w) begin
               if (bit_q == '0) begin
                  state_d = HOLD;
                  hold_d  = '0;
                  sh_d    = '0;
               end else begin
                  sh_d = {sh_q[FRAME_WIDTH-2:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         hold_q  <= '0;
         sh_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         hold_q  <= hold_d;
         sh_q    <= sh_d;
         done_q  <= done_d;
      end
   end

   assign dac_cs_n   = (state_q != SHIFT);
   assign dac_sclk   = sclk_w;
   assign dac_mosi   = sh_q[FRAME_WIDTH-1];
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;

`ifdef DAC_TX_LDAC_EN
   assign dac_ldac_n = !((state_q == HOLD) && (hold_q >= HOLD_W'(CS_GAP)));
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: directed frame table, multi-cycle corner sequences,
// then random traffic checked every cycle against a cycle-offset pin model.
module tb_dac_spi_tx;

   localparam int DW  = 8;
   localparam int FW  = 16;
   localparam int DIV = 2;
   localparam int GAP = 2;
   localparam int T_CS = 2 * DIV * FW;
`ifdef DAC_TX_LDAC_EN
   localparam int T_HOLD = GAP + DIV;
`else
   localparam int T_HOLD = GAP;
`endif
   localparam int T_DONE = T_CS + T_HOLD + 1;

   logic          clk = 1'b0;
   logic          rst, en, sample_valid;
   logic [DW-1:0] sample;
   logic          sample_ready, dac_cs_n, dac_sclk, dac_mosi, busy, frame_done;
   logic          ldac_obs;

   dac_spi_tx #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .CLK_DIV(DIV), .CS_GAP(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_valid (sample_valid),
      .sample       (sample),
      .sample_ready (sample_ready),
      .dac_cs_n     (dac_cs_n),
      .dac_sclk     (dac_sclk),
      .dac_mosi     (dac_mosi),
      .busy         (busy),
      .frame_done   (frame_done)
`ifdef DAC_TX_LDAC_EN
      ,.dac_ldac_n  (ldac_obs)
`endif
   );
`ifndef DAC_TX_LDAC_EN
   assign ldac_obs = 1'b1;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic logic [FW-1:0] model_frame(logic [DW-1:0] s);
      int f;
      f = (3 << (FW - 4)) + (int'(s) << (FW - 4 - DW));
      return FW'(f);
   endfunction

   // Reference model: all pins follow from the cycle offset since the last accept.
   bit            acc_vld = 1'b0;
   int            acc_cyc = 0;
   logic [FW-1:0] acc_frame = '0;
   // Independent capture of what a DAC would latch on each sclk rise.
   logic [FW-1:0] cap = '0;
   logic [FW-1:0] cap_q[$];
   logic          prev_cs = 1'b1, prev_sclk = 1'b0;
   int            cs_fall_cyc = 0, cs_rise_cyc = 0, last_gap = 0;
   int            fall_cnt = 0, done_cnt = 0;

   always @(negedge clk) begin
      logic e_rdy, e_cs, e_sclk, e_mosi, e_busy, e_done, e_ldac;
      int o;
      e_rdy = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_ldac = 1'b1;
      if (rst) begin
         acc_vld = 1'b0;
      end else begin
         o = acc_vld ? (cyc - acc_cyc) : (1 << 20);
         e_busy = (o >= 1) && (o <= T_DONE - 1);
         e_done = (o == T_DONE);
         e_cs   = !((o >= 1) && (o <= T_CS));
         if (!e_cs) begin
            e_sclk = (((o - 1) % (2 * DIV)) >= DIV);
            e_mosi = acc_frame[FW - 1 - (o - 1) / (2 * DIV)];
         end
`ifdef DAC_TX_LDAC_EN
         e_ldac = !((o >= T_CS + 1 + GAP) && (o <= T_CS + GAP + DIV));
`endif
         e_rdy = en && !e_busy;
      end
      chk("pins{rdy,cs_n,sclk,mosi,busy,done,ldac_n}",
          {sample_ready, dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, ldac_obs},
          {e_rdy, e_cs, e_sclk, e_mosi, e_busy, e_done, e_ldac});
      if (!rst && sample_valid && e_rdy) begin
         acc_vld   = 1'b1;
         acc_cyc   = cyc;
         acc_frame = model_frame(sample);
      end

      if (!dac_cs_n && prev_cs) begin
         cap = '0;
         last_gap = cyc - cs_rise_cyc;
         cs_fall_cyc = cyc;
         fall_cnt++;
      end
      if (!dac_cs_n && dac_sclk && !prev_sclk) cap = {cap[FW-2:0], dac_mosi};
      if (dac_cs_n && !prev_cs) begin
         cap_q.push_back(cap);
         cs_rise_cyc = cyc;
      end
      if (frame_done) done_cnt++;
      prev_cs = dac_cs_n;
      prev_sclk = dac_sclk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers s until it is accepted; returns the accept cycle.
   task automatic send(input logic [DW-1:0] s, output int acc_c);
      bit ok = 1'b0;
      acc_c = 0;
      sample = s;
      sample_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (sample_ready) begin
            ok = 1'b1;
            acc_c = cyc;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_done(output int done_c);
      bit ok = 1'b0;
      done_c = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (frame_done) begin
            ok = 1'b1;
            done_c = cyc;
            break;
         end
      end
      if (!ok) chk("done_timeout", 0, 1);
      tick();
   endtask

   function automatic logic [FW-1:0] cap_at(int i);
      if (cap_q.size() > i) return cap_q[i];
      return 'x;
   endfunction

   typedef struct {
      logic [DW-1:0] s;
      logic [FW-1:0] exp;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int a1, a2, d1, d0;
      logic [DW-1:0] held;

      tbl[0] = '{8'hA5, 16'h3A50};
      tbl[1] = '{8'h00, 16'h3000};
      tbl[2] = '{8'hFF, 16'h3FF0};
      tbl[3] = '{8'h5A, 16'h35A0};
      tbl[4] = '{8'h01, 16'h3010};
      tbl[5] = '{8'h80, 16'h3800};

      rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample = '0;
      repeat (3) tick();
      chk("reset_ready", sample_ready, 0);
      chk("reset_cs_n", dac_cs_n, 1);
      chk("reset_sclk", dac_sclk, 0);
      chk("reset_mosi", dac_mosi, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", frame_done, 0);
      en = 1'b1;
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         cap_q.delete();
         send(tbl[i].s, a1);
         wait_done(d1);
         chk("frame", cap_at(0), tbl[i].exp);
         chk("latency", d1 - a1, T_DONE);
         chk("cs_low_len", cs_rise_cyc - cs_fall_cyc, T_CS);
      end

      // Back-to-back with valid held high.
      cap_q.delete();
      sample = 8'h00; sample_valid = 1'b1;
      send(8'h00, a1);
      sample_valid = 1'b1; sample = 8'hFF;
      send(8'hFF, a2);
      wait_done(d1);
      chk("b2b_period", a2 - a1, T_DONE);
      chk("b2b_frame0", cap_at(0), 16'h3000);
      chk("b2b_frame1", cap_at(1), 16'h3FF0);
      chk("b2b_cs_gap", last_gap, T_HOLD + 1);

      // Changing sample while busy: the value at the accept edge is transmitted.
      cap_q.delete();
      send(8'h11, a1);
      sample_valid = 1'b1;
      a2 = 0; held = '0;
      for (int k = 0; k < 400; k++) begin
         sample = DW'($urandom);
         @(negedge clk);
         if (sample_ready) begin
            a2 = cyc;
            held = sample;
            break;
         end
         tick();
      end
      tick();
      sample_valid = 1'b0;
      wait_done(d1);
      chk("hs_period", a2 - a1, T_DONE);
      chk("hs_frame", cap_at(1), model_frame(held));

      // en dropped mid-frame: frame completes, nothing new starts.
      cap_q.delete();
      send(8'h33, a1);
      en = 1'b0; sample = 8'h44; sample_valid = 1'b1;
      wait_done(d1);
      d0 = fall_cnt;
      repeat (20) tick();
      chk("en_low_no_frame", fall_cnt - d0, 0);
      chk("en_low_ready", sample_ready, 0);
      chk("en_low_frame", cap_at(0), 16'h3330);
      en = 1'b1;
      send(8'h44, a1);
      wait_done(d1);
      chk("en_resume_frame", cap_at(1), 16'h3440);

      // Reset in bit 7's high phase (frame bit 7 is 1 for sample 0F).
      send(8'h0F, a1);
      repeat (34) tick();
      d0 = done_cnt;
      chk("pre_abort_cs_n", dac_cs_n, 0);
      rst = 1'b1;
      #1;
      chk("abort_cs_n", dac_cs_n, 1);
      chk("abort_sclk", dac_sclk, 0);
      chk("abort_mosi", dac_mosi, 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (80) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      cap_q.delete();
      send(8'h5A, a1);
      wait_done(d1);
      chk("post_abort_frame", cap_at(0), 16'h35A0);

      // Random traffic, en toggling and occasional reset pulses.
      for (int k = 0; k < 4000; k++) begin
         sample_valid = ($urandom_range(3) != 0);
         sample = DW'($urandom);
         if ($urandom_range(49) == 0) en = !en;
         rst = ($urandom_range(799) == 0);
         tick();
      end
      rst = 1'b0; en = 1'b1; sample_valid = 1'b0;
      repeat (T_DONE + 5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
